multicycle_ctrl_fsm: RTL and testbench

- Main control unit for the multi-cycle RISC-V core, directly upstream of the ALU decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives the datapath enables and mux selects.
- Its alu_op output feeds the ALU decoder's Aluop input with this encoding:
  - 00 = add
  - 01 = sub
  - 10 = R-type, resolved by funct3/funct7
  - 11 = I-type ALU, resolved by funct3
- Supported opcodes: lw, sw, R-type (add/sub/and/or/xor), I-type ALU (addi/andi/ori), beq, jal.

---
 rtl/multicycle_ctrl_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//   Main control unit of the multi-cycle RISC-V core. Sequences each
//   instruction through fetch/decode/execute/memory/writeback and drives
//   the datapath enables and mux selects. alu_op feeds the ALU decoder:
//   00 add, 01 sub, 10 R-type (funct3/funct7), 11 I-type ALU (funct3).
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   op[6:0]     in   opcode field of the instruction register
//   zero        in   ALU zero flag (used only in BEQ)
//   pc_write    out  PC enable = pc_update | (branch & zero)
//   adr_src     out  memory address select: 0 PC, 1 ALUOut
//   mem_write   out  data memory write enable
//   ir_write    out  instruction register / OldPC enable
//   result_src  out  00 ALUOut, 01 memory data, 10 ALU result
//   alu_src_a   out  00 PC, 01 OldPC, 10 rs1
//   alu_src_b   out  00 rs2, 01 immediate, 10 constant 4
//   alu_op      out  ALU decoder operation class
//   reg_write   out  register file write enable
//   imm_src     out  immediate format, combinational from op
//   instr_done  out  one-cycle pulse in the final state of an instruction
//   illegal_op  out  high while in TRAP
//   state_o     out  current state encoding, for debug
//
// Handshake: none. The FSM free-runs; op must stay stable from DECODE to
// the end of the instruction, which holds because ir_write is 0 there.

module multicycle_ctrl_fsm #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] imm_src,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t state;
    state_t next_state;
    logic   pc_update;
    logic   branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_update  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // OldPC + imm: branch target is ready for BEQ.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXEC_R;
                    OP_I:         next_state = S_EXEC_I;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
                    default: begin
                        if (TRAP_ON_ILLEGAL) begin
                            next_state = S_TRAP;
                        end else begin
                            // Skipped opcode: PC was already advanced in FETCH.
                            next_state = S_FETCH;
                            instr_done = 1'b1;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                next_state = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b11;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                // OldPC + 4 is the link value written back in ALUWB;
                // the jump target (OldPC + imm) sits in ALUOut from DECODE.
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_update  = 1'b1;
                next_state = S_ALUWB;
            end
            S_TRAP: begin
                illegal_op = 1'b1;
                next_state = S_TRAP;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // zero only matters while branch is high, i.e. in BEQ.
    assign pc_write = pc_update | (branch & zero);

    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

  localparam int W = 21;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic       zero;

  // instance with TRAP_ON_ILLEGAL=1
  logic       pcw_t, adr_t, mw_t, irw_t, rw_t, done_t, ill_t;
  logic [1:0] rs_t, sa_t, sb_t, aop_t, imm_t;
  logic [3:0] st_t;
  // instance with TRAP_ON_ILLEGAL=0
  logic       pcw_s, adr_s, mw_s, irw_s, rw_s, done_s, ill_s;
  logic [1:0] rs_s, sa_s, sb_s, aop_s, imm_s;
  logic [3:0] st_s;

  multicycle_ctrl_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut_trap (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .pc_write(pcw_t), .adr_src(adr_t), .mem_write(mw_t), .ir_write(irw_t),
    .result_src(rs_t), .alu_src_a(sa_t), .alu_src_b(sb_t), .alu_op(aop_t),
    .reg_write(rw_t), .imm_src(imm_t), .instr_done(done_t),
    .illegal_op(ill_t), .state_o(st_t)
  );

  multicycle_ctrl_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut_skip (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .pc_write(pcw_s), .adr_src(adr_s), .mem_write(mw_s), .ir_write(irw_s),
    .result_src(rs_s), .alu_src_a(sa_s), .alu_src_b(sb_s), .alu_op(aop_s),
    .reg_write(rw_s), .imm_src(imm_s), .instr_done(done_s),
    .illegal_op(ill_s), .state_o(st_s)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];    // trap instance
  logic [W-1:0] exp0_q[$];   // skip instance
  logic [W-1:0] sched [0:31];
  logic [W-1:0] s1 [0:31];
  logic [W-1:0] s0 [0:31];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Vector layout: state, pc_write, adr_src, mem_write, ir_write,
  // result_src, alu_src_a, alu_src_b, alu_op, reg_write, imm_src,
  // instr_done, illegal_op.
  function automatic logic [W-1:0] mk(input int st, input logic pcw, input logic adr,
                                      input logic mw, input logic irw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] aop, input logic rw,
                                      input logic [1:0] imm, input logic done,
                                      input logic ill);
    logic [3:0] s4;
    s4 = st[3:0];
    return {s4, pcw, adr, mw, irw, rs, sa, sb, aop, rw, imm, done, ill};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // Instruction-level model: the per-cycle output schedule of one instruction.
  task automatic build(input logic [6:0] o, input logic z, input bit trap, output int len);
    logic [1:0] im;
    logic [W-1:0] aluwb;
    bit legal;
    im = imm_of(o);
    legal = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
            (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
    aluwb = mk(8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, im, 1, 0);
    sched[0] = mk(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, im, 0, 0);
    sched[1] = mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, im, (!legal && !trap), 0);
    len = 2;
    case (o)
      7'b0000011: begin
        sched[2] = mk(2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, im, 0, 0);
        sched[3] = mk(3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, im, 0, 0);
        sched[4] = mk(4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, im, 1, 0);
        len = 5;
      end
      7'b0100011: begin
        sched[2] = mk(2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, im, 0, 0);
        sched[3] = mk(5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, im, 1, 0);
        len = 4;
      end
      7'b0110011: begin
        sched[2] = mk(6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, im, 0, 0);
        sched[3] = aluwb;
        len = 4;
      end
      7'b0010011: begin
        sched[2] = mk(7, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b11, 0, im, 0, 0);
        sched[3] = aluwb;
        len = 4;
      end
      7'b1100011: begin
        sched[2] = mk(9, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, im, 1, 0);
        len = 3;
      end
      7'b1101111: begin
        sched[2] = mk(10, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, im, 0, 0);
        sched[3] = aluwb;
        len = 4;
      end
      default: begin
        if (trap) begin
          sched[2] = mk(11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, im, 0, 1);
          len = 3;
        end
      end
    endcase
  endtask

  // Runs one instruction on both instances. trap_len extends a TRAP stay;
  // cut>0 stops after cut cycles with reset asserted on the last edge.
  task automatic run(input logic [6:0] o, input logic z, input int trap_len, input int cut,
                     input int exp_len);
    int len1, len0, n;
    build(o, z, 1'b1, len1);
    for (int i = 0; i < len1; i++) s1[i] = sched[i];
    for (int i = len1; i < len1 + trap_len - 1; i++) s1[i] = s1[len1 - 1];
    if (trap_len > 1) len1 = len1 + trap_len - 1;
    build(o, z, 1'b0, len0);
    for (int i = 0; i < len0; i++) s0[i] = sched[i];
    // the skip instance keeps looping FETCH/DECODE on an unsupported opcode
    for (int i = len0; i < len1; i++) s0[i] = s0[i % 2];
    if (exp_len > 0) check($sformatf("latency_%b", o), len1, exp_len);
    n = (cut > 0) ? cut : len1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(s1[i]);
      exp0_q.push_back(s0[i]);
    end
    op = o;
    zero = z;
    if (cut > 0) begin
      repeat (n - 1) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
    end else begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // ---------------- compare process ----------------
  logic [W-1:0] act_t, act_s, e;
  assign act_t = {st_t, pcw_t, adr_t, mw_t, irw_t, rs_t, sa_t, sb_t, aop_t, rw_t, imm_t, done_t, ill_t};
  assign act_s = {st_s, pcw_s, adr_s, mw_s, irw_s, rs_s, sa_s, sb_s, aop_s, rw_s, imm_s, done_s, ill_s};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs_trap_inst", act_t, e);
    end
    if (exp0_q.size() > 0) begin
      e = exp0_q.pop_front();
      check("outputs_skip_inst", act_s, e);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    op = 7'b0000000;
    zero = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    check("reset_state", st_t, 4'd0);
    check("reset_ir_write", irw_t, 1'b1);
    check("reset_pc_write", pcw_t, 1'b1);
    check("reset_alu_src_b", sb_t, 2'b10);
    check("reset_alu_op", aop_t, 2'b00);

    run(7'b0000011, 1'b1, 0, 0, 5);   // lw, zero ignored
    run(7'b0100011, 1'b0, 0, 0, 4);   // sw
    run(7'b0110011, 1'b1, 0, 0, 4);   // R-type
    run(7'b0010011, 1'b0, 0, 0, 4);   // I-type
    run(7'b1100011, 1'b1, 0, 0, 3);   // beq taken
    run(7'b1100011, 1'b0, 0, 0, 3);   // beq not taken
    run(7'b1101111, 1'b1, 0, 0, 4);   // jal
    run(7'b1111111, 1'b0, 10, 12, 0); // TRAP held 10 cycles, then reset
    run(7'b0010011, 1'b0, 0, 0, 4);
    run(7'b0000000, 1'b1, 3, 5, 0);   // another unsupported opcode
    run(7'b0100011, 1'b0, 0, 4, 0);   // reset in MEMWRITE
    run(7'b0000011, 1'b0, 0, 4, 0);   // reset in MEMREAD
    run(7'b0000011, 1'b1, 0, 0, 5);
    run(7'b0110011, 1'b0, 0, 0, 4);

    @(posedge clk);
    #1;
    check("queue_drained", exp_q.size() + exp0_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
